// File: rtl/debounced_switch_led_ctrl_if.sv
// Switch/LED bus between the debounce controller and its user.
// The master side drives raw switches and the LED mode; the slave side
// (the controller) returns debounced levels, rise pulses and LED drive.
interface debounced_switch_led_ctrl_if #(
    parameter int N = 4
);
    logic [N-1:0] i_switch;
    logic [1:0]   i_mode;
    logic [N-1:0] o_LED;
    logic [N-1:0] o_sw_stable;
    logic [N-1:0] o_sw_rise;

    modport master (
        output i_switch, i_mode,
        input  o_LED, o_sw_stable, o_sw_rise
    );

    modport slave (
        input  i_switch, i_mode,
        output o_LED, o_sw_stable, o_sw_rise
    );
endinterface

// File: rtl/debounced_switch_led_ctrl.sv
// Per-channel switch debouncer with rise detection, feeding an LED driver
// that can show the level directly, a press-toggled state, a blinking
// level, or nothing. One lane instance per channel; blink timing shared.

// One switch channel: synchronize, debounce, flag debounced 0->1 edges.
module dbnc_lane #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_ff;
    logic [CW-1:0] cnt;
    logic          sync;

    assign sync = sync_ff[1];

    // two-flop synchronizer for the asynchronous switch level
    always_ff @(posedge clk) begin
        if (rst) sync_ff <= '0;
        else     sync_ff <= {sync_ff[0], raw};
    end

    // count consecutive cycles of disagreement; accept the new level on the
    // last one. Any agreement in between restarts the count (glitch reject).
    // rise is set on the same edge stable goes 0->1, so it is a 1-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                stable <= sync;
                rise   <= sync;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module debounced_switch_led_ctrl #(
    parameter int N                 = 4,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int BLINK_HALF_PERIOD = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    debounced_switch_led_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    localparam int BW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);

    logic [N-1:0]  stable_v;
    logic [N-1:0]  rise_v;
    logic [N-1:0]  toggle_q;
    logic [N-1:0]  led_q;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    for (genvar g = 0; g < N; g++) begin : g_lane
        dbnc_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_lane (
            .clk    (i_clk),
            .rst    (i_rst),
            .raw    (bus.i_switch[g]),
            .stable (stable_v[g]),
            .rise   (rise_v[g])
        );
    end

    // toggle state flips on every debounced press, whatever the LED mode
    always_ff @(posedge i_clk) begin
        if (i_rst) toggle_q <= '0;
        else       toggle_q <= toggle_q ^ rise_v;
    end

    // free-running blink timebase: phase flips every BLINK_HALF_PERIOD cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // registered LED mux; mode only selects the source, it holds no state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            led_q <= '0;
        end else begin
            case (mode_e'(bus.i_mode))
                MODE_DIRECT: led_q <= stable_v;
                MODE_TOGGLE: led_q <= toggle_q;
                MODE_BLINK:  led_q <= stable_v & {N{blink_phase}};
                default:     led_q <= '0;
            endcase
        end
    end

    assign bus.o_LED       = led_q;
    assign bus.o_sw_stable = stable_v;
    assign bus.o_sw_rise   = rise_v;
endmodule

// File: tb/tb_debounced_switch_led_ctrl.sv
// Directed bench for debounced_switch_led_ctrl (N=4, DEBOUNCE_CYCLES=4,
// BLINK_HALF_PERIOD=3). Inputs change 1ns after a rising edge; outputs are
// checked at that same point, i.e. they reflect the edge just taken.
module tb_debounced_switch_led_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   k;       // edges since the last reset edge (blink timebase model)
    int   pulses;

    debounced_switch_led_ctrl_if #(.N(4)) bus ();

    debounced_switch_led_ctrl #(
        .N                 (4),
        .DEBOUNCE_CYCLES   (4),
        .BLINK_HALF_PERIOD (3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) k = 0;
        else     k++;
        #1;
    endtask

    logic [3:0] bounce_pat;
    logic [3:0] exp_led;

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_tests = 0;
        n_fail  = 0;
        k       = 0;
        bus.i_switch = 4'b0000;
        bus.i_mode   = 2'b00;

        // reset state
        tick();
        chk("rst_led",    {28'd0, bus.o_LED},       32'h0);
        chk("rst_stable", {28'd0, bus.o_sw_stable}, 32'h0);
        chk("rst_rise",   {28'd0, bus.o_sw_rise},   32'h0);
        tick();
        rst = 1'b0;

        // clean step 0000 -> 0101, direct mode
        bus.i_switch = 4'b0101;
        repeat (5) tick();
        chk("step_pre", {28'd0, bus.o_sw_stable}, 32'h0);
        tick();
        chk("step_stable", {28'd0, bus.o_sw_stable}, 32'h5);
        chk("step_rise",   {28'd0, bus.o_sw_rise},   32'h5);
        chk("step_led_lat", {28'd0, bus.o_LED},      32'h0);
        tick();
        chk("step_rise_end", {28'd0, bus.o_sw_rise}, 32'h0);
        chk("step_led",      {28'd0, bus.o_LED},     32'h5);

        // release all, then bounce channel 0: 1,0,1,0 then hold 1
        bus.i_switch = 4'b0000;
        repeat (8) tick();
        chk("rel_stable", {28'd0, bus.o_sw_stable}, 32'h0);
        bounce_pat = 4'b0101;   // applied LSB first: 1,0,1,0
        for (int i = 0; i < 4; i++) begin
            bus.i_switch = {3'b000, bounce_pat[i]};
            tick();
            chk("bounce_glitch", {28'd0, bus.o_sw_stable}, 32'h0);
        end
        bus.i_switch = 4'b0001;
        repeat (4) tick();
        for (int i = 0; i < 1; i++) begin
            tick();
            chk("bounce_hold", {28'd0, bus.o_sw_stable}, 32'h0);
        end
        tick();
        chk("bounce_stable", {28'd0, bus.o_sw_stable}, 32'h1);
        chk("bounce_rise",   {28'd0, bus.o_sw_rise},   32'h1);
        tick();
        chk("bounce_rise_end", {28'd0, bus.o_sw_rise}, 32'h0);

        // simultaneous: ch0 rises while ch3 falls
        bus.i_switch = 4'b1000;
        repeat (8) tick();
        chk("sim_setup", {28'd0, bus.o_sw_stable}, 32'h8);
        bus.i_switch = 4'b0001;
        repeat (5) tick();
        chk("sim_pre", {28'd0, bus.o_sw_stable}, 32'h8);
        tick();
        chk("sim_stable", {28'd0, bus.o_sw_stable}, 32'h1);
        chk("sim_rise",   {28'd0, bus.o_sw_rise},   32'h1);
        tick();
        chk("sim_rise_end", {28'd0, bus.o_sw_rise}, 32'h0);

        // toggle mode from a fresh reset: press/release channel 2 twice
        rst = 1'b1;
        tick();
        chk("rst2_led",    {28'd0, bus.o_LED},       32'h0);
        chk("rst2_stable", {28'd0, bus.o_sw_stable}, 32'h0);
        chk("rst2_rise",   {28'd0, bus.o_sw_rise},   32'h0);
        rst = 1'b0;
        bus.i_switch = 4'b0000;
        bus.i_mode   = 2'b01;
        bus.i_switch = 4'b0100;
        repeat (7) tick();
        chk("tog_lat", {28'd0, bus.o_LED}, 32'h0);
        tick();
        chk("tog_press1", {28'd0, bus.o_LED}, 32'h4);
        bus.i_switch = 4'b0000;
        repeat (8) tick();
        chk("tog_rel1", {28'd0, bus.o_LED}, 32'h4);
        bus.i_switch = 4'b0100;
        repeat (8) tick();
        chk("tog_press2", {28'd0, bus.o_LED}, 32'h0);
        bus.i_switch = 4'b0000;
        repeat (8) tick();
        chk("tog_rel2", {28'd0, bus.o_LED}, 32'h0);

        // blink: all switches on (also toggles every channel to 1)
        bus.i_switch = 4'b1111;
        repeat (8) tick();
        chk("blink_tog_setup", {28'd0, bus.o_LED}, 32'hF);
        bus.i_mode = 2'b10;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_led = (((k - 1) / 3) % 2 != 0) ? 4'hF : 4'h0;
            chk("blink", {28'd0, bus.o_LED}, {28'd0, exp_led});
        end
        bus.i_mode = 2'b11;
        tick();
        chk("mode_off", {28'd0, bus.o_LED}, 32'h0);
        bus.i_mode = 2'b01;
        tick();
        chk("mode_tog_kept", {28'd0, bus.o_LED}, 32'hF);

        // reset in the middle of a debounce count
        bus.i_mode   = 2'b00;
        bus.i_switch = 4'b0000;
        repeat (8) tick();
        chk("mid_setup", {28'd0, bus.o_sw_stable}, 32'h0);
        bus.i_switch = 4'b1111;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_led",    {28'd0, bus.o_LED},       32'h0);
        chk("mid_rst_stable", {28'd0, bus.o_sw_stable}, 32'h0);
        chk("mid_rst_rise",   {28'd0, bus.o_sw_rise},   32'h0);
        rst = 1'b0;
        repeat (5) tick();
        chk("mid_pre", {28'd0, bus.o_sw_stable}, 32'h0);
        tick();
        chk("mid_stable", {28'd0, bus.o_sw_stable}, 32'hF);
        chk("mid_rise",   {28'd0, bus.o_sw_rise},   32'hF);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.o_sw_rise != 4'b0000) pulses++;
        end
        chk("mid_single_rise", pulses, 32'd0);
        chk("mid_led", {28'd0, bus.o_LED}, 32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
